// File: rtl/wb_irq_ctrl_if.sv
// wb_if: pipelined Wishbone B4 bus bundle with master/slave views
interface wb_if;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        stall;
  logic        err;
  modport master(output adr, dat_m, sel, we, cyc, stb, input dat_s, ack, stall, err);
  modport slave(input adr, dat_m, sel, we, cyc, stb, output dat_s, ack, stall, err);
endinterface

// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl: Wishbone-mapped interrupt controller with edge/level sources and claim register
module wb_irq_ctrl #(
  parameter int NSRC = 15
) (
  input  logic            clk,
  input  logic            rst,
  wb_if.slave             wb,
  input  logic [NSRC-1:0] irq_src,
  output logic [14:0]     irq_fast,
  output logic            irq_external
);
  logic [NSRC-1:0] s1, s2, s3, pending, enable, edge_r;
  logic [NSRC-1:0] msk, wdat, clr, swset, set_e, pend_n, act;
  logic [31:0] wmask, rdat, claim;
  logic [2:0] off;
  logic acc, wr, unused;
  assign acc = wb.cyc & wb.stb;
  assign wr = acc & wb.we;
  assign off = wb.adr[4:2];
  assign wmask = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}};
  assign msk = wmask[NSRC-1:0];
  assign wdat = wb.dat_m[NSRC-1:0] & msk;
  assign clr = (wr && off == 3'd0) ? wdat : '0;
  assign swset = (wr && off == 3'd4) ? wdat : '0;
  assign set_e = s2 & ~s3;
  // set events are ORed in after the clear so they win a same-cycle W1C
  assign pend_n = (edge_r & ((pending & ~clr) | set_e | swset)) | (~edge_r & s2);
  assign act = pending & enable;
  assign irq_fast = 15'(act);
  assign irq_external = |act;
  assign wb.stall = 1'b0;
  assign wb.err = 1'b0;
  assign unused = ^{wb.adr[31:5], wb.adr[1:0], wb.dat_m};
  assign rdat = off == 3'd0 ? 32'(pending) :
                off == 3'd1 ? 32'(enable) :
                off == 3'd2 ? 32'(edge_r) :
                off == 3'd3 ? claim : '0;
  // lowest-numbered active source wins; scanning downward leaves it last
  always_comb begin
    claim = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (act[i]) claim = 32'(i + 1);
  end
  // two-flop synchronizer plus one history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
      s3 <= s2;
    end
  end
  // interrupt state registers with byte-lane write enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      enable <= '0;
      edge_r <= '0;
    end else begin
      pending <= pend_n;
      if (wr && off == 3'd1) enable <= (enable & ~msk) | wdat;
      if (wr && off == 3'd2) edge_r <= (edge_r & ~msk) | wdat;
    end
  end
  // single-cycle ack with read data captured from pre-write register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.ack <= 1'b0;
      wb.dat_s <= '0;
    end else begin
      wb.ack <= acc;
      if (acc) wb.dat_s <= rdat;
    end
  end
endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb_wb_irq_ctrl: directed scoreboard bench for wb_irq_ctrl
module tb_wb_irq_ctrl;
  localparam int NSRC = 15;
  localparam logic [31:0] MSK = 32'h0000_7FFF;
  logic clk, rst;
  logic [NSRC-1:0] irq_src;
  logic [14:0] irq_fast;
  logic irq_external;
  int checks = 0;
  int failures = 0;
  logic [32:0] exq[$];
  string tagq[$];
  wb_if wb();
  wb_irq_ctrl #(.NSRC(NSRC)) dut (
    .clk(clk),
    .rst(rst),
    .wb(wb.slave),
    .irq_src(irq_src),
    .irq_fast(irq_fast),
    .irq_external(irq_external)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic c, input logic [31:0] e, input string tag);
    logic had;
    logic [32:0] ent;
    string t;
    @(posedge clk);
    had = wb.cyc & wb.stb;
    #1;
    wb.cyc = v;
    wb.stb = v;
    wb.we = w;
    wb.adr = a;
    wb.dat_m = d;
    wb.sel = s;
    if (v) begin
      exq.push_back({c, e});
      tagq.push_back(tag);
    end
    @(negedge clk);
    chk("ack", 32'(wb.ack), 32'(had));
    if (had) begin
      ent = exq.pop_front();
      t = tagq.pop_front();
      if (ent[32]) chk(t, wb.dat_s, ent[31:0]);
    end
  endtask
  task automatic idle();
    xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, "idle");
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    xfer(1'b1, 1'b0, a, 32'h0, 4'hF, 1'b1, e, tag);
    idle();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(1'b1, 1'b1, a, d, s, 1'b0, 32'h0, "wr");
    idle();
  endtask
  initial begin
    rst = 1'b1;
    irq_src = '0;
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    wb.we = 1'b0;
    wb.adr = '0;
    wb.dat_m = '0;
    wb.sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fast", 32'(irq_fast), 32'h0);
    chk("rst_ext", 32'(irq_external), 32'h0);
    chk("rst_dat", wb.dat_s, 32'h0);
    chk("rst_stall_err", {30'h0, wb.stall, wb.err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h00, 32'h0, "rst_pending");
    rd(32'h04, 32'h0, "rst_enable");
    // edge-mode pulse on source 0
    wr(32'h04, 32'h1, 4'hF);
    wr(32'h08, 32'h1, 4'hF);
    irq_src[0] = 1'b1;
    idle();
    irq_src[0] = 1'b0;
    idle();
    chk("lat_k1_fast", 32'(irq_fast), 32'h0);
    idle();
    chk("lat_k2_fast", 32'(irq_fast), 32'h1);
    chk("lat_k2_ext", 32'(irq_external), 32'h1);
    rd(32'h0C, 32'h1, "claim_1");
    rd(32'h0C, 32'h1, "claim_1_again");
    wr(32'h00, 32'h1, 4'hF);
    chk("w1c_fast", 32'(irq_fast), 32'h0);
    chk("w1c_ext", 32'(irq_external), 32'h0);
    // source edge lands in the same cycle as the W1C
    irq_src[0] = 1'b1;
    idle();
    wr(32'h00, 32'h1, 4'hF);
    chk("set_wins_fast", 32'(irq_fast), 32'h1);
    rd(32'h00, 32'h1, "set_wins_pend");
    irq_src[0] = 1'b0;
    idle();
    idle();
    wr(32'h00, 32'h1, 4'hF);
    rd(32'h00, 32'h0, "w1c_clear_pend");
    // level mode on source 3
    wr(32'h04, 32'h8, 4'hF);
    irq_src[3] = 1'b1;
    idle();
    idle();
    idle();
    rd(32'h00, 32'h8, "level_pend");
    wr(32'h00, 32'h8, 4'hF);
    rd(32'h00, 32'h8, "level_w1c_ignored");
    wr(32'h10, 32'h8, 4'hF);
    rd(32'h0C, 32'h4, "level_claim");
    irq_src[3] = 1'b0;
    idle();
    chk("level_drop_k", 32'(irq_fast), 32'h8);
    idle();
    chk("level_drop_k1", 32'(irq_fast), 32'h8);
    idle();
    chk("level_drop_k2", 32'(irq_fast), 32'h0);
    rd(32'h00, 32'h0, "level_drop_pend");
    // software set and byte-lane writes
    wr(32'h04, 32'h4, 4'hF);
    wr(32'h08, 32'h6, 4'hF);
    wr(32'h10, 32'h6, 4'hF);
    rd(32'h00, 32'h6, "swset_pend");
    chk("swset_fast", 32'(irq_fast), 32'h4);
    rd(32'h0C, 32'h3, "swset_claim");
    wr(32'h04, 32'hFFFF, 4'b0010);
    rd(32'h04, 32'hFF04 & MSK, "sel_enable");
    rd(32'h08, 32'h6, "edge_readback");
    // back-to-back strobes
    xfer(1'b1, 1'b0, 32'h00, 32'h0, 4'hF, 1'b1, 32'h6, "b2b_rd_pend");
    xfer(1'b1, 1'b1, 32'h04, 32'h0123, 4'hF, 1'b0, 32'h0, "b2b_wr");
    xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, 1'b1, 32'h0123, "b2b_rd_enable");
    idle();
    idle();
    rd(32'h1C, 32'h0, "unmapped");
    rd(32'h10, 32'h0, "swset_read");
    wr(32'h0C, 32'hFFFF, 4'hF);
    rd(32'h0C, 32'h2, "claim_ro");
    // all sources pending, then reset mid-transfer
    wr(32'h08, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'hFFFF_FFFF, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    rd(32'h00, 32'h7FFF, "all_pend");
    chk("all_fast", 32'(irq_fast), 32'h7FFF);
    chk("all_ext", 32'(irq_external), 32'h1);
    @(posedge clk);
    #1;
    wb.cyc = 1'b1;
    wb.stb = 1'b1;
    wb.we = 1'b0;
    wb.adr = 32'h00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_fast", 32'(irq_fast), 32'h0);
    chk("arst_ext", 32'(irq_external), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_no_ack", 32'(wb.ack), 32'h0);
    chk("arst_dat", wb.dat_s, 32'h0);
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(32'h00, 32'h0, "post_rst_pend");
    rd(32'h04, 32'h0, "post_rst_enable");
    rd(32'h08, 32'h0, "post_rst_edge");
    rd(32'h0C, 32'h0, "post_rst_claim");
    chk("scoreboard_empty", 32'(exq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
